// File: rtl/csr_trap_writer.sv
// ----------------------------------------------------------------------------
// csr_trap_writer
//
// Producer side of the register-file CSR write-back port. Accepts one
// CSR-class operation per handshake from EXU: CSRRW/CSRRS/CSRRC, ECALL, MRET,
// or a pending machine-timer interrupt. New CSR values are computed from the
// current register-file CSR outputs and presented as a one-cycle write pulse
// in the cycle after acceptance. The same pulse carries the old CSR value
// for rd and, for traps/returns, a fetch redirect.
//
// Parameters
//   XLEN    data width (only 64 is supported)
//   IRQ_EN  1: honour mtip; 0: mtip ignored and mip[7] never changes
//
// Ports
//   clock, reset             system clock, synchronous active-high reset
//   in_valid / in_ready      EXU handshake; in_ready is high only when idle
//   in_op                    0 NONE, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL,
//                            5 MRET; other encodings behave as NONE
//   in_pc                    pc of the operation
//   in_csr_addr, in_src      CSR address and rs1 value for CSR ops
//   mepc..mip                current CSR values from the register file
//   mtip                     machine timer interrupt level
//   wbcsren                  per-CSR write enables [0]mepc [1]mcause
//                            [2]mtvec [3]mstatus [4]mie [5]mip, [7:6]=0
//   wbmepc..wbmip            new CSR values, qualified by wbcsren
//   rd_valid, rd_data        old CSR value for rd (pulse)
//   redirect_valid/_pc       fetch restart target (pulse)
// ----------------------------------------------------------------------------
module csr_trap_writer #(
    parameter int XLEN   = 64,
    parameter bit IRQ_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_src,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mcause,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    input  logic            mtip,
    output logic [7:0]      wbcsren,
    output logic [XLEN-1:0] wbmepc,
    output logic [XLEN-1:0] wbmcause,
    output logic [XLEN-1:0] wbmtvec,
    output logic [XLEN-1:0] wbmstatus,
    output logic [XLEN-1:0] wbmie,
    output logic [XLEN-1:0] wbmip,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } state_e;

    localparam logic [2:0] OpCsrrw = 3'd1;
    localparam logic [2:0] OpCsrrs = 3'd2;
    localparam logic [2:0] OpCsrrc = 3'd3;
    localparam logic [2:0] OpEcall = 3'd4;
    localparam logic [2:0] OpMret  = 3'd5;

    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMie     = 12'h304;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [11:0] AddrMip     = 12'h344;

    localparam logic [XLEN-1:0] CauseMti   = {1'b1, {(XLEN-5){1'b0}}, 4'h7};
    localparam logic [XLEN-1:0] CauseEcall = {{(XLEN-4){1'b0}}, 4'hB};

    // Write-enable bit positions inside wbcsren
    localparam int EnMepc    = 0;
    localparam int EnMcause  = 1;
    localparam int EnMtvec   = 2;
    localparam int EnMstatus = 3;
    localparam int EnMie     = 4;
    localparam int EnMip     = 5;

    state_e          state_q, state_d;
    logic [7:0]      wbcsren_q, wbcsren_d;
    logic [XLEN-1:0] wbmepc_q, wbmepc_d;
    logic [XLEN-1:0] wbmcause_q, wbmcause_d;
    logic [XLEN-1:0] wbmtvec_q, wbmtvec_d;
    logic [XLEN-1:0] wbmstatus_q, wbmstatus_d;
    logic [XLEN-1:0] wbmie_q, wbmie_d;
    logic [XLEN-1:0] wbmip_q, wbmip_d;
    logic            rdValid_q, rdValid_d;
    logic [XLEN-1:0] rdData_q, rdData_d;
    logic            redirValid_q, redirValid_d;
    logic [XLEN-1:0] redirPc_q, redirPc_d;

    logic            inReady;
    logic            accept;
    logic            mipSync;
    logic            irqPend;
    logic            mipBit7;
    logic            csrHit;
    logic            csrWrite;
    logic [XLEN-1:0] csrOld;
    logic [XLEN-1:0] csrNew;
    logic [XLEN-1:0] trapStatus;
    logic [XLEN-1:0] mretStatus;
    logic [XLEN-1:0] trapTarget;

    // Handshake, interrupt qualification and the pure datapath that derives
    // candidate CSR values from the register-file outputs. A timer level that
    // disagrees with mip[7] needs a write to bring mip back in line.
    always_comb begin
        inReady  = (state_q == StIdle) && !reset;
        accept   = in_valid && inReady;
        mipSync  = IRQ_EN && (mip[7] != mtip);
        irqPend  = IRQ_EN && mstatus[3] && mie[7] && mtip;
        mipBit7  = IRQ_EN ? mtip : mip[7];

        csrHit = 1'b1;
        case (in_csr_addr)
            AddrMstatus: csrOld = mstatus;
            AddrMie:     csrOld = mie;
            AddrMtvec:   csrOld = mtvec;
            AddrMepc:    csrOld = mepc;
            AddrMcause:  csrOld = mcause;
            AddrMip:     csrOld = mip;
            default: begin
                csrOld = '0;
                csrHit = 1'b0;
            end
        endcase

        case (in_op)
            OpCsrrs: csrNew = csrOld | in_src;
            OpCsrrc: csrNew = csrOld & ~in_src;
            default: csrNew = in_src;
        endcase

        // Set/clear with a zero mask is a pure read and must not write.
        csrWrite = csrHit && ((in_op == OpCsrrw) || (in_src != '0));

        // Trap entry stacks MIE into MPIE; MRET restores it. MPP is pinned
        // to machine mode because this hart has no other privilege level.
        trapStatus        = mstatus;
        trapStatus[7]     = mstatus[3];
        trapStatus[3]     = 1'b0;
        trapStatus[12:11] = 2'b11;

        mretStatus        = mstatus;
        mretStatus[3]     = mstatus[7];
        mretStatus[7]     = 1'b1;
        mretStatus[12:11] = 2'b11;

        trapTarget = {mtvec[XLEN-1:2], 2'b00};
    end

    // Next-state and pulse generation. Pulse flags default to zero so that
    // every issue lasts exactly one cycle; wbm* data defaults to holding.
    always_comb begin
        logic            doTrap;
        logic [XLEN-1:0] trapCause;

        state_d      = state_q;
        wbcsren_d    = '0;
        rdValid_d    = 1'b0;
        redirValid_d = 1'b0;
        wbmepc_d     = wbmepc_q;
        wbmcause_d   = wbmcause_q;
        wbmtvec_d    = wbmtvec_q;
        wbmstatus_d  = wbmstatus_q;
        wbmie_d      = wbmie_q;
        wbmip_d      = wbmip_q;
        rdData_d     = rdData_q;
        redirPc_d    = redirPc_q;
        doTrap       = 1'b0;
        trapCause    = CauseEcall;

        case (state_q)
            StIdle: begin
                if (accept || mipSync) begin
                    state_d = StIssue;

                    if (accept) begin
                        // A pending interrupt pre-empts whatever EXU sent.
                        if (irqPend) begin
                            doTrap    = 1'b1;
                            trapCause = CauseMti;
                        end else begin
                            case (in_op)
                                OpCsrrw, OpCsrrs, OpCsrrc: begin
                                    rdValid_d = 1'b1;
                                    rdData_d  = csrOld;
                                    if (csrWrite) begin
                                        case (in_csr_addr)
                                            AddrMstatus: begin
                                                wbcsren_d[EnMstatus] = 1'b1;
                                                wbmstatus_d          = csrNew;
                                            end
                                            AddrMie: begin
                                                wbcsren_d[EnMie] = 1'b1;
                                                wbmie_d          = csrNew;
                                            end
                                            AddrMtvec: begin
                                                wbcsren_d[EnMtvec] = 1'b1;
                                                wbmtvec_d          = csrNew;
                                            end
                                            AddrMepc: begin
                                                wbcsren_d[EnMepc] = 1'b1;
                                                wbmepc_d          = csrNew;
                                            end
                                            AddrMcause: begin
                                                wbcsren_d[EnMcause] = 1'b1;
                                                wbmcause_d          = csrNew;
                                            end
                                            AddrMip: begin
                                                wbcsren_d[EnMip] = 1'b1;
                                                wbmip_d          = csrNew;
                                            end
                                            default: ;
                                        endcase
                                    end
                                end
                                OpEcall: begin
                                    doTrap    = 1'b1;
                                    trapCause = CauseEcall;
                                end
                                OpMret: begin
                                    wbcsren_d[EnMstatus] = 1'b1;
                                    wbmstatus_d          = mretStatus;
                                    redirValid_d         = 1'b1;
                                    redirPc_d            = mepc;
                                end
                                default: ;
                            endcase
                        end
                    end

                    if (doTrap) begin
                        wbcsren_d[EnMepc]    = 1'b1;
                        wbcsren_d[EnMcause]  = 1'b1;
                        wbcsren_d[EnMstatus] = 1'b1;
                        wbmepc_d             = in_pc;
                        wbmcause_d           = trapCause;
                        wbmstatus_d          = trapStatus;
                        redirValid_d         = 1'b1;
                        redirPc_d            = trapTarget;
                    end

                    // Resync of mip rides on this pulse; if software is also
                    // writing mip its value is kept, only bit 7 is forced.
                    if (mipSync && !wbcsren_d[EnMip]) begin
                        wbcsren_d[EnMip] = 1'b1;
                        wbmip_d          = mip;
                    end
                    if (wbcsren_d[EnMip]) begin
                        wbmip_d[7] = mipBit7;
                    end
                end
            end
            StIssue: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears pulses and data alike.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            wbcsren_q    <= '0;
            wbmepc_q     <= '0;
            wbmcause_q   <= '0;
            wbmtvec_q    <= '0;
            wbmstatus_q  <= '0;
            wbmie_q      <= '0;
            wbmip_q      <= '0;
            rdValid_q    <= 1'b0;
            rdData_q     <= '0;
            redirValid_q <= 1'b0;
            redirPc_q    <= '0;
        end else begin
            state_q      <= state_d;
            wbcsren_q    <= wbcsren_d;
            wbmepc_q     <= wbmepc_d;
            wbmcause_q   <= wbmcause_d;
            wbmtvec_q    <= wbmtvec_d;
            wbmstatus_q  <= wbmstatus_d;
            wbmie_q      <= wbmie_d;
            wbmip_q      <= wbmip_d;
            rdValid_q    <= rdValid_d;
            rdData_q     <= rdData_d;
            redirValid_q <= redirValid_d;
            redirPc_q    <= redirPc_d;
        end
    end

    // The pulse registers were loaded at the accepting edge, so a reset
    // raised during the issue cycle has to mask them directly to cancel it.
    assign in_ready       = inReady;
    assign wbcsren        = reset ? 8'h00 : wbcsren_q;
    assign rd_valid       = rdValid_q && !reset;
    assign redirect_valid = redirValid_q && !reset;
    assign wbmepc         = wbmepc_q;
    assign wbmcause       = wbmcause_q;
    assign wbmtvec        = wbmtvec_q;
    assign wbmstatus      = wbmstatus_q;
    assign wbmie          = wbmie_q;
    assign wbmip          = wbmip_q;
    assign rd_data        = rdData_q;
    assign redirect_pc    = redirPc_q;

endmodule
